bench_result_uart_tx: RTL
=========================

BENCH_RESULT_UART_TX -- requirements
Module: bench_result_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1085, giving sysclk cycles per UART bit (125 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have port sysclk, input, 1, the single clock; all logic is rising-edge on sysclk.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port done, input, 1, one-cycle pulse from the benchmark engine marking valid results.
REQ-005 SHALL have port winner_code, input, 2, the winning condition index.
REQ-006 SHALL have ports t_cond0, t_cond1, t_cond2 and t_cond3, each input, 32, the per-condition cycle counts.
REQ-007 SHALL have port uart_tx, output, 1, the serial line; idle level is 1.
REQ-008 SHALL have port busy, output, 1, high while a frame is in flight.
REQ-009 SHALL have port frame_sent, output, 1, one-cycle pulse when a frame completes.
REQ-010 SHALL have port overrun, output, 1, sticky flag set when a done pulse is dropped.

Function
REQ-011 SHALL, on done=1 with busy=0, latch winner_code and t_cond0..t_cond3 in that cycle; input changes after the latch SHALL NOT affect the frame.
REQ-012 SHALL transmit a fixed 19-byte frame in this order:
- byte 0: 0xA5.
- byte 1: {6'b0, winner_code}.
- bytes 2-17: t_cond0, t_cond1, t_cond2, t_cond3, each most-significant byte first.
- byte 18: checksum = XOR of bytes 1..17 (the header is excluded).
REQ-013 SHALL send each byte as 8N1 with no gap between bytes or inside a byte:
- one start bit (0);
- 8 data bits, LSB first;
- one stop bit (1);
- every bit held exactly CLKS_PER_BIT cycles.
REQ-014 SHALL use the states IDLE -> START -> DATA -> STOP, with these transitions:
- STOP -> START when the byte index is below 18;
- STOP -> IDLE after byte 18.
- The bit counter runs 0..7 in DATA.
- The byte index runs 0..18.
REQ-015 SHALL drive uart_tx low and busy high in the first cycle after the accepted done (1-cycle latency).
REQ-016 SHALL hold busy high for exactly 190*CLKS_PER_BIT cycles.
REQ-017 SHALL, in the cycle after the last stop-bit cycle, drive busy=0 and frame_sent=1 for one cycle, with uart_tx=1.
REQ-018 SHALL, when done=1 arrives while busy=1 (including the final stop-bit cycle), ignore the pulse, leave the frame unaltered, and set overrun=1.
REQ-019 SHALL accept a done pulse in the same cycle frame_sent=1, because busy=0 in that cycle.
REQ-020 SHALL clear overrun only by rst.
REQ-021 SHALL keep uart_tx registered (glitch-free) and equal to 1 in IDLE.
REQ-022 SHALL compute the checksum on the latched data, either incrementally or precomputed at latch; either method gives the same byte 18.

Reset
REQ-023 SHALL, in the cycle after rst=1, drive uart_tx=1, busy=0, frame_sent=0 and overrun=0, with state=IDLE and all counters=0.
REQ-024 SHALL, when rst is asserted mid-frame, abort the frame with no further bits sent and no frame_sent pulse.
REQ-025 SHALL give rst priority over a simultaneous done, so that no frame starts.

Verification (CLKS_PER_BIT=4)
REQ-026 SHALL cover the nominal frame: t0=0x10, t1=0x20, t2=0x30, t3=0x08, winner=3, done pulse.
- Decoded bytes: A5 03 00 00 00 10 00 00 00 20 00 00 00 30 00 00 00 08 0B.
- busy high 760 cycles, then frame_sent pulses once.
REQ-027 SHALL cover input isolation: t_cond0 changed to 0xFFFFFFFF two cycles after done -> frame still carries 0x00000010 and checksum 0x0B.
REQ-028 SHALL cover overrun: a second done at cycle 100 of a frame -> frame unchanged, overrun=1, no second frame; overrun stays 1 until rst.
REQ-029 SHALL cover back-to-back frames: done in the frame_sent cycle -> uart_tx falls the next cycle and the second frame decodes correctly; overrun=0.
REQ-030 SHALL cover reset mid-frame: rst during byte 5 -> next cycle uart_tx=1, busy=0, no frame_sent; a following done sends a full, correct frame.
REQ-031 SHALL cover checksum coverage: t0..t3=0xFFFFFFFF, winner=2 -> checksum byte=0x02, and every bit period measures exactly 4 cycles.

Source files
------------

// File: rtl/bench_result_uart_tx.sv
// Serialises one benchmark result (winner index plus four cycle counts) as a 19-byte
// 8N1 UART frame: 0xA5 header, payload MSB-first, XOR checksum of bytes 1..17.
module bench_result_uart_tx #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        done,
  input  logic [1:0]  winner_code,
  input  logic [31:0] t_cond0,
  input  logic [31:0] t_cond1,
  input  logic [31:0] t_cond2,
  input  logic [31:0] t_cond3,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_sent,
  output logic        overrun
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  BYTE_LAST = 5'd18;
  localparam logic [7:0]  HEADER    = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  tx_state_t    state_r;
  logic [15:0]  clk_cnt_r;
  logic [2:0]   bit_cnt_r;
  logic [4:0]   byte_idx_r;
  logic [1:0]   winner_r;
  logic [127:0] times_r;
  logic [7:0]   csum_r;
  logic         uart_tx_r;
  logic         busy_r;
  logic         frame_sent_r;
  logic         overrun_r;

  logic [127:0] times_shift_s;
  logic [7:0]   cur_byte_s;
  logic [2:0]   next_bit_s;
  logic         bit_end_s;

  // Checksum over the winner byte and the sixteen count bytes (header excluded).
  function automatic logic [7:0] calc_csum(input logic [1:0] w, input logic [127:0] t);
    logic [7:0] acc;
    acc = {6'b000000, w};
    for (int i = 0; i < 16; i++) begin
      acc = acc ^ t[i*8 +: 8];
    end
    return acc;
  endfunction

  // Selects the byte currently on the wire from the latched frame contents.
  always_comb begin
    times_shift_s = times_r << {byte_idx_r - 5'd2, 3'b000};
    next_bit_s    = bit_cnt_r + 3'd1;
    bit_end_s     = (clk_cnt_r == BIT_LAST);
    case (byte_idx_r)
      5'd0:      cur_byte_s = HEADER;
      5'd1:      cur_byte_s = {6'b000000, winner_r};
      BYTE_LAST: cur_byte_s = csum_r;
      default:   cur_byte_s = times_shift_s[127:120];
    endcase
  end

  // Frame sequencer: bit timing, byte walk, line drive and status flags.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      clk_cnt_r    <= 16'd0;
      bit_cnt_r    <= 3'd0;
      byte_idx_r   <= 5'd0;
      winner_r     <= 2'd0;
      times_r      <= 128'd0;
      csum_r       <= 8'd0;
      uart_tx_r    <= 1'b1;
      busy_r       <= 1'b0;
      frame_sent_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      frame_sent_r <= 1'b0;
      // busy_r is still high during the final stop-bit cycle, so a pulse there is dropped too
      if (done && busy_r) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          uart_tx_r <= 1'b1;
          if (done) begin
            winner_r   <= winner_code;
            times_r    <= {t_cond0, t_cond1, t_cond2, t_cond3};
            csum_r     <= calc_csum(winner_code, {t_cond0, t_cond1, t_cond2, t_cond3});
            state_r    <= ST_START;
            uart_tx_r  <= 1'b0;
            busy_r     <= 1'b1;
            clk_cnt_r  <= 16'd0;
            bit_cnt_r  <= 3'd0;
            byte_idx_r <= 5'd0;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            clk_cnt_r <= 16'd0;
            bit_cnt_r <= 3'd0;
            state_r   <= ST_DATA;
            uart_tx_r <= cur_byte_s[0];
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            clk_cnt_r <= 16'd0;
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
              state_r   <= ST_STOP;
              uart_tx_r <= 1'b1;
            end else begin
              bit_cnt_r <= next_bit_s;
              uart_tx_r <= cur_byte_s[next_bit_s];
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            clk_cnt_r <= 16'd0;
            if (byte_idx_r == BYTE_LAST) begin
              byte_idx_r   <= 5'd0;
              state_r      <= ST_IDLE;
              uart_tx_r    <= 1'b1;
              busy_r       <= 1'b0;
              frame_sent_r <= 1'b1;
            end else begin
              byte_idx_r <= byte_idx_r + 5'd1;
              state_r    <= ST_START;
              uart_tx_r  <= 1'b0;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          uart_tx_r <= 1'b1;
          busy_r    <= 1'b0;
          clk_cnt_r <= 16'd0;
        end
      endcase
    end
  end

  assign uart_tx    = uart_tx_r;
  assign busy       = busy_r;
  assign frame_sent = frame_sent_r;
  assign overrun    = overrun_r;

endmodule
